// File: rtl/rvv_uop_queue.sv
// rtl/rvv_uop_queue.sv - in-order RVV uop FIFO between decoder and dispatch; optional RVV_UQ_OCCUPANCY_EN adds uq_count/uq_almost_full
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif

module rvv_uop_queue #(
    parameter int DEPTH   = 16,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = `NUM_DP_UOP,
    parameter int UOP_W   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_IN-1:0]                uops_valid_dc2uq,
    input  logic [NUM_IN-1:0][UOP_W-1:0]     uops_dc2uq,
    output logic [NUM_IN-1:0]                uops_ready_uq2dc,
    output logic [NUM_OUT-1:0]               uops_valid_uq2dp,
    output logic [NUM_OUT-1:0][UOP_W-1:0]    uops_uq2dp,
    input  logic [NUM_OUT-1:0]               uops_ready_dp2uq,
    input  logic                             flush
`ifdef RVV_UQ_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]       uq_count,
    output logic                             uq_almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(NUM_IN+1);
    localparam int QW = $clog2(NUM_OUT+1);

    logic [UOP_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic [PW-1:0]    push_cnt;
    logic [QW-1:0]    pop_cnt;
    logic             push_run;
    logic             pop_run;

    // Decoder ready comes only from registered occupancy, so a same-cycle pop never frees a slot
    always_comb begin
        uops_ready_uq2dc = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            uops_ready_uq2dc[i] = !rst && ((DEPTH - int'(count)) > i);
        end
    end

    // Accept only the leading run of lanes that are both valid and ready
    always_comb begin
        push_run = 1'b1;
        push_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (push_run && uops_valid_dc2uq[i] && uops_ready_uq2dc[i]) begin
                push_cnt = push_cnt + PW'(1);
            end else begin
                push_run = 1'b0;
            end
        end
    end

    // Present the oldest entries; valid is purely a function of occupancy
    always_comb begin
        uops_valid_uq2dp = '0;
        uops_uq2dp       = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            uops_valid_uq2dp[j] = int'(count) > j;
            uops_uq2dp[j]       = mem[rptr + AW'(j)];
        end
    end

    // Pop only the in-order prefix of lanes dispatch has taken; a gap stops the run
    always_comb begin
        pop_run = 1'b1;
        pop_cnt = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (pop_run && uops_valid_uq2dp[j] && uops_ready_dp2uq[j]) begin
                pop_cnt = pop_cnt + QW'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    // Pointer and occupancy update; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + AW'(pop_cnt);
            wptr  <= wptr + AW'(push_cnt);
            count <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    // Entry storage is not reset; the pointers alone define what is live
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (k < int'(push_cnt)) begin
                    mem[wptr + AW'(k)] <= uops_dc2uq[k];
                end
            end
        end
    end

`ifdef RVV_UQ_OCCUPANCY_EN
    // Occupancy taps for decoder throttling and performance counters
    always_comb begin
        uq_count       = count;
        uq_almost_full = count >= CW'(DEPTH - NUM_IN);
    end
`endif

endmodule
